// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC control, imem read, decode buffer
module ifetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_we,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state, state_nx;
  logic            drop, drop_nx;
  logic [XLEN-1:0] req_pc;
  logic            accept;
  logic            load;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc_in;

  always_comb begin
    state_nx = state;
    drop_nx  = drop;
    accept   = (state == S_HOLD) && if_ready && !redirect;
    load     = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        // a redirect racing the grant leaves one stale response to discard
        if (imem_gnt) begin
          state_nx = S_WAIT;
          drop_nx  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nx = (drop || redirect) ? S_REQ : S_HOLD;
          drop_nx  = 1'b0;
        end else if (redirect) begin
          drop_nx = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || if_ready) state_nx = S_REQ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pc_we   = 1'b0;
    pc_next = pc_in;
    if (!reset) begin
      pc_we   = 1'b1;
      pc_next = RESET_PC;
    end else if (redirect) begin
      pc_we   = 1'b1;
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (accept) begin
      pc_we   = 1'b1;
      pc_next = req_pc + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      drop     <= 1'b0;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (state == S_REQ && imem_gnt) req_pc <= pc_in;
      if (load) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= req_pc;
      end else if (redirect || accept) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed vector bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  ifetch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_we(pc_we), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        we;
    logic [31:0] nxt;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic [31:0] pc, input logic redir,
                     input logic [31:0] rpc, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic rdy, input logic we,
                     input logic [31:0] nxt, input logic req, input logic valid,
                     input logic [31:0] instr, input logic [31:0] ipc);
    vec_t v;
    v.rst = rst; v.pc = pc; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.rdy = rdy; v.we = we; v.nxt = nxt; v.req = req;
    v.valid = valid; v.instr = instr; v.ipc = ipc;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'h5A5A_0000;

  logic        we_d, pend;
  logic [31:0] nxt_d, rd_addr, exp_pc;
  int          last_acc, n_acc;

  initial begin
    reset = 1'b0; pc_in = 32'h40; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

    //  rst pc            redir rpc           gnt rv rdata          rdy  we nxt           req val instr          ipc
    add(0, 32'h40,        0, 0,               0, 0, 0,             0,   1, 32'h0,        0, 0, NOP,           32'h0);
    add(0, 32'h0,         0, 0,               0, 0, 0,             0,   1, 32'h0,        0, 0, NOP,           32'h0);
    add(1, 32'h0,         1, 32'h101,         0, 0, 0,             0,   1, 32'h100,      0, 0, NOP,           32'h0);
    add(1, 32'h100,       0, 0,               0, 0, 0,             0,   0, 32'h100,      1, 0, NOP,           32'h0);
    add(1, 32'h100,       0, 0,               1, 0, 0,             0,   0, 32'h100,      1, 0, NOP,           32'h0);
    add(1, 32'h100,       0, 0,               0, 1, 32'h00A00093,  0,   0, 32'h100,      0, 0, NOP,           32'h0);
    add(1, 32'h100,       0, 0,               0, 0, 0,             1,   1, 32'h104,      0, 1, 32'h00A00093,  32'h100);
    add(1, 32'h104,       0, 0,               1, 0, 0,             0,   0, 32'h104,      1, 0, NOP,           32'h100);
    add(1, 32'h104,       0, 0,               0, 1, 32'h00100113,  0,   0, 32'h104,      0, 0, NOP,           32'h100);
    for (int i = 0; i < 5; i++)
      add(1, 32'h104,     0, 0,               0, 0, 0,             0,   0, 32'h104,      0, 1, 32'h00100113,  32'h104);
    add(1, 32'h104,       0, 0,               0, 0, 0,             1,   1, 32'h108,      0, 1, 32'h00100113,  32'h104);
    add(1, 32'h108,       0, 0,               1, 0, 0,             0,   0, 32'h108,      1, 0, NOP,           32'h104);
    add(1, 32'h108,       1, 32'h203,         0, 0, 0,             0,   1, 32'h200,      0, 0, NOP,           32'h104);
    add(1, 32'h200,       0, 0,               0, 1, 32'hDEADBEEF,  0,   0, 32'h200,      0, 0, NOP,           32'h104);
    add(1, 32'h200,       0, 0,               1, 0, 0,             0,   0, 32'h200,      1, 0, NOP,           32'h104);
    add(1, 32'h200,       0, 0,               0, 1, 32'h12345678,  0,   0, 32'h200,      0, 0, NOP,           32'h104);
    add(1, 32'h200,       1, 32'h80,          0, 0, 0,             1,   1, 32'h80,       0, 1, 32'h12345678,  32'h200);
    add(1, 32'h80,        0, 0,               0, 0, 0,             0,   0, 32'h80,       1, 0, NOP,           32'h200);
    add(1, 32'h80,        1, 32'h300,         1, 0, 0,             0,   1, 32'h300,      1, 0, NOP,           32'h200);
    add(1, 32'h300,       0, 0,               0, 1, 32'h0000AAAA,  0,   0, 32'h300,      0, 0, NOP,           32'h200);
    add(1, 32'h300,       0, 0,               1, 0, 0,             0,   0, 32'h300,      1, 0, NOP,           32'h200);
    add(1, 32'h300,       1, 32'hFFFFFFFE,    0, 1, 32'h0000BBBB,  0,   1, 32'hFFFFFFFC, 0, 0, NOP,           32'h200);
    add(1, 32'hFFFFFFFC,  0, 0,               1, 0, 0,             0,   0, 32'hFFFFFFFC, 1, 0, NOP,           32'h200);
    add(1, 32'hFFFFFFFC,  0, 0,               0, 1, 32'h00000073,  0,   0, 32'hFFFFFFFC, 0, 0, NOP,           32'h200);
    add(1, 32'hFFFFFFFC,  0, 0,               0, 0, 0,             1,   1, 32'h0,        0, 1, 32'h00000073,  32'hFFFFFFFC);
    add(1, 32'h0,         0, 0,               1, 0, 0,             0,   0, 32'h0,        1, 0, NOP,           32'hFFFFFFFC);
    add(0, 32'h0,         0, 0,               0, 0, 0,             0,   1, 32'h0,        0, 0, NOP,           32'hFFFFFFFC);
    add(1, 32'h0,         0, 0,               0, 1, 32'h0000CCCC,  0,   0, 32'h0,        0, 0, NOP,           32'h0);
    add(1, 32'h0,         0, 0,               0, 0, 0,             0,   0, 32'h0,        1, 0, NOP,           32'h0);
    add(1, 32'h0,         1, 32'h44,          0, 0, 0,             0,   1, 32'h44,       1, 0, NOP,           32'h0);
    add(1, 32'h44,        0, 0,               0, 0, 0,             0,   0, 32'h44,       1, 0, NOP,           32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; pc_in = vq[i].pc; redirect = vq[i].redir; redirect_pc = vq[i].rpc;
      imem_gnt = vq[i].gnt; imem_rvalid = vq[i].rv; imem_rdata = vq[i].rdata;
      if_ready = vq[i].rdy;
      #1;
      check($sformatf("vec%0d", i),
            {125'b0, pc_we, pc_next, imem_req, imem_addr, if_valid, if_instr, if_pc},
            {125'b0, vq[i].we, vq[i].nxt, vq[i].req, vq[i].pc, vq[i].valid, vq[i].instr, vq[i].ipc});
    end

    // zero-wait memory loop: expect an accept every third cycle
    we_d = 1'b0; pend = 1'b0; nxt_d = '0; rd_addr = '0; exp_pc = 32'h44;
    last_acc = -1; n_acc = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (we_d) pc_in = nxt_d;
      reset = 1'b1; redirect = 1'b0; if_ready = 1'b1; imem_gnt = 1'b0;
      imem_rvalid = pend; imem_rdata = rd_addr ^ K;
      #1;
      imem_gnt = imem_req;
      #1;
      pend = imem_req;
      if (imem_req) rd_addr = imem_addr;
      we_d = pc_we; nxt_d = pc_next;
      if (pc_we) begin
        check("zw_pc", {224'b0, if_pc}, {224'b0, exp_pc});
        check("zw_instr", {224'b0, if_instr}, {224'b0, exp_pc ^ K});
        check("zw_next", {224'b0, pc_next}, {224'b0, exp_pc + 32'd4});
        if (last_acc >= 0) check("zw_gap", 256'(c - last_acc), 256'(3));
        last_acc = c;
        n_acc++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    check("zw_count", 256'(n_acc), 256'(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
